// File: rtl/gate_identifier.sv
// Gate identifier: collects (a, b, y) observations of an unknown 2-input gate,
// builds its truth table and reports which standard gate it matches.
// Optional macro CANDIDATES_EN adds the cand[6:0] output and early reporting.
module gate_identifier #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       a,
  input  logic       b,
  input  logic       y,
  output logic       res_valid,
  input  logic       res_ack,
  output logic [2:0] gate_code,
  output logic       conflict,
  output logic       timeout,
  output logic [3:0] rows_seen
`ifdef CANDIDATES_EN
  ,
  output logic [6:0] cand
`endif
);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_REPORT  = 2'd1;
  localparam logic [1:0] ST_ERROR   = 2'd2;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [3:0]       truth;
  logic [3:0]       seen;
  logic [2:0]       code;
  logic             conflict_q;
  logic             timeout_q;
  logic [CNT_W-1:0] idle_cnt;

  logic [1:0] row;
  logic       accept;
  logic       row_known;
  logic       row_mismatch;
  logic [3:0] truth_upd;
  logic [3:0] seen_upd;
  logic       full_upd;
  logic       idle_hit;
  logic       flush;

  // Truth table of gate code k; bit i is the output for row {a,b} = i.
  function automatic logic [3:0] pattern(input logic [2:0] k);
    logic [3:0] p;
    case (k)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1110;
      3'd2:    p = 4'b0011;
      3'd3:    p = 4'b0111;
      3'd4:    p = 4'b0001;
      3'd5:    p = 4'b0110;
      3'd6:    p = 4'b1001;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] decode(input logic [3:0] t);
    logic [2:0] r;
    r = 3'd7;
    for (int k = 6; k >= 0; k--) begin
      if (t == pattern(3'(k))) r = 3'(k);
    end
    return r;
  endfunction

`ifdef CANDIDATES_EN
  function automatic logic [6:0] consistent(input logic [3:0] t, input logic [3:0] s);
    logic [6:0] c;
    c = '0;
    for (int k = 0; k < 7; k++) begin
      c[k] = (((t ^ pattern(3'(k))) & s) == 4'b0000);
    end
    return c;
  endfunction

  function automatic logic [2:0] first_set(input logic [6:0] c);
    logic [2:0] r;
    r = 3'd7;
    for (int k = 6; k >= 0; k--) begin
      if (c[k]) r = 3'(k);
    end
    return r;
  endfunction

  logic [6:0] cand_upd;
  logic       early_go;
  logic [2:0] early_code;

  // Early report: the table after this accept leaves a single consistent gate.
  assign cand_upd   = consistent(truth_upd, seen_upd);
  assign early_go   = $onehot(cand_upd) && ($countones(seen_upd) >= 3);
  assign early_code = first_set(cand_upd);
  assign cand       = (state == ST_ERROR) ? 7'd0 : consistent(truth, seen);
`endif

  assign in_ready     = (state == ST_COLLECT);
  assign res_valid    = (state != ST_COLLECT);
  assign gate_code    = code;
  assign conflict     = conflict_q;
  assign timeout      = timeout_q;
  assign rows_seen    = seen;

  assign row          = {a, b};
  assign accept       = in_valid && in_ready;
  assign row_known    = seen[row];
  assign row_mismatch = row_known && (truth[row] != y);
  assign full_upd     = &seen_upd;
  assign idle_hit     = TO_EN && (seen != 4'b0000) && (idle_cnt == TO_LAST);
  assign flush        = clear || ((state != ST_COLLECT) && res_ack);

  always_comb begin
    truth_upd      = truth;
    seen_upd       = seen;
    truth_upd[row] = y;
    seen_upd[row]  = 1'b1;
  end

  // clear and a consumed result both return to an empty COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_COLLECT;
      truth      <= 4'b0000;
      seen       <= 4'b0000;
      code       <= 3'd7;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      idle_cnt   <= '0;
    end else if (flush) begin
      state      <= ST_COLLECT;
      truth      <= 4'b0000;
      seen       <= 4'b0000;
      code       <= 3'd7;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (accept) begin
            idle_cnt <= '0;
            if (row_mismatch) begin
              state      <= ST_ERROR;
              conflict_q <= 1'b1;
            end else if (!row_known) begin
              truth <= truth_upd;
              seen  <= seen_upd;
              if (full_upd) begin
                state <= ST_REPORT;
                code  <= decode(truth_upd);
              end
`ifdef CANDIDATES_EN
              else if (early_go) begin
                state <= ST_REPORT;
                code  <= early_code;
              end
`endif
            end
          end else if (idle_hit) begin
            state     <= ST_ERROR;
            timeout_q <= 1'b1;
            idle_cnt  <= '0;
          end else if (TO_EN && (seen != 4'b0000)) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        ST_REPORT: begin
          idle_cnt <= '0;
        end
        ST_ERROR: begin
          idle_cnt <= '0;
        end
        default: begin
          state    <= ST_COLLECT;
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule
